reg_bank_reader: RTL
====================

REG_BANK_READER -- requirements
Module: reg_bank_reader

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 4, width of each register value read.
REQ-002 SHALL have parameter NUM_REGS, default 6, number of registers presented on regs_i.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, width of req_addr_i.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port regs_i  input  NUM_REGS*REGISTER_WIDTH  flattened register outputs; register k occupies bits [k*REGISTER_WIDTH +: REGISTER_WIDTH].
REQ-007 SHALL have port req_valid_i  input  1  read request valid.
REQ-008 SHALL have port req_addr_i  input  ADDR_WIDTH  register index to read.
REQ-009 SHALL have port req_ready_o  output  1  request can be accepted.
REQ-010 SHALL have port resp_valid_o  output  1  resp_data_o/resp_err_o valid.
REQ-011 SHALL have port resp_ready_i  input  1  consumer takes response.
REQ-012 SHALL have port resp_data_o  output  REGISTER_WIDTH  read data of oldest pending response.
REQ-013 SHALL have port resp_err_o  output  1  oldest response had out-of-range address (READ_ERR_EN only; else tied 0).
REQ-014 SHALL have port rd_count_o  output  8  count of responses consumed, wraps 255->0.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid_i && req_ready_o.
REQ-016 SHALL sample the addressed register from regs_i at the accepting edge; later changes to regs_i SHALL NOT alter a queued response.
REQ-017 SHALL buffer responses in a 2-entry in-order queue with states EMPTY, ONE, FULL.
REQ-018 SHALL drive req_ready_o = 1 in EMPTY and ONE, 0 in FULL (combinational from state only, not from resp_ready_i).
REQ-019 SHALL drive resp_valid_o = 1 in ONE and FULL, 0 in EMPTY; resp_data_o/resp_err_o SHALL show the oldest entry and hold stable while resp_valid_o && !resp_ready_i.
REQ-020 SHALL pop the oldest entry on an edge where resp_valid_o && resp_ready_i.
REQ-021 Latency: response for a request accepted at edge N SHALL be visible on resp_valid_o after edge N when the queue was EMPTY.
REQ-022 Transitions: EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on simultaneous push and pop; FULL->ONE on pop; no push in FULL.
REQ-023 SHALL increment rd_count_o by 1 on each pop, modulo 256.
REQ-024 SHALL drive resp_data_o to 0 whenever resp_valid_o = 0.

Reset
REQ-025 On reset_i = 1 at a rising edge: state EMPTY, both queue entries and error flags cleared, rd_count_o = 0.
REQ-026 After reset: req_ready_o = 1, resp_valid_o = 0, resp_data_o = 0, resp_err_o = 0.
REQ-027 Reset SHALL override simultaneous push and pop; pending responses SHALL be discarded without incrementing rd_count_o.

Configuration
REQ-028 Macro READ_ERR_EN SHALL select out-of-range handling.
REQ-029 With READ_ERR_EN defined: address >= NUM_REGS SHALL queue resp_data_o = 0 with resp_err_o = 1; in-range reads set resp_err_o = 0.
REQ-030 Without READ_ERR_EN: address SHALL be reduced modulo NUM_REGS (e.g. 6 -> 0, 7 -> 1) and resp_err_o SHALL be constant 0.

Verification
REQ-031 Reset held 4 cycles -> req_ready_o=1, resp_valid_o=0, resp_data_o=0, rd_count_o=0.
REQ-032 regs_i reg2=4'b1010, request addr 2 with resp_ready_i=1 -> resp_valid_o=1 with data 4'b1010 one edge after accept, rd_count_o=1 after the pop edge.
REQ-033 resp_ready_i=0, requests addr 0 (4'b0001) then addr 5 (4'b1110) -> FULL, req_ready_o=0; change regs_i -> outputs still 4'b0001 then 4'b1110 after pops.
REQ-034 In ONE state, push and pop on same edge, back-to-back for 10 cycles -> state stays ONE, rd_count_o advances by 10, data in order.
REQ-035 Request addr 7: READ_ERR_EN defined -> data 0, resp_err_o=1; undefined -> data equals reg1, resp_err_o=0.
REQ-036 Reset asserted while FULL -> next cycle EMPTY, resp_valid_o=0, rd_count_o=0.

Source files
------------

// File: rtl/reg_bank_reader.sv
// Register-bank read port with a 2-entry in-order response queue.
// Optional macro READ_ERR_EN: out-of-range addresses return data 0 with resp_err_o=1 (else address wraps modulo NUM_REGS).
module reg_bank_reader #(
    parameter int REGISTER_WIDTH = 4,
    parameter int NUM_REGS       = 6,
    parameter int ADDR_WIDTH     = 3
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [NUM_REGS*REGISTER_WIDTH-1:0] regs_i,
    input  logic                               req_valid_i,
    input  logic [ADDR_WIDTH-1:0]              req_addr_i,
    output logic                               req_ready_o,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [REGISTER_WIDTH-1:0]          resp_data_o,
    output logic                               resp_err_o,
    output logic [7:0]                         rd_count_o,
    output logic [1:0]                         state_o
);
    // Handshake: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and payload holds while valid && !ready.

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Entry layout: {err, data}; head is the oldest entry.
    typedef logic [REGISTER_WIDTH:0] entry_t;

    state_t state, state_next;
    entry_t head, head_next;
    entry_t tail, tail_next;
    logic [7:0] rd_count;

    logic [REGISTER_WIDTH-1:0] rd_data;
    logic                      rd_err;
    entry_t                    new_entry;
    logic                      push;
    logic                      pop;

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
`ifdef READ_ERR_EN
        rd_err = (32'(req_addr_i) >= 32'(NUM_REGS));
        for (int k = 0; k < NUM_REGS; k++) begin
            if (32'(req_addr_i) == 32'(k)) begin
                rd_data = regs_i[k*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
`else
        for (int k = 0; k < NUM_REGS; k++) begin
            if ((32'(req_addr_i) % 32'(NUM_REGS)) == 32'(k)) begin
                rd_data = regs_i[k*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
`endif
    end

    assign new_entry    = {rd_err, rd_data};
    assign req_ready_o  = (state != FULL);
    assign resp_valid_o = (state != EMPTY);
    assign push         = req_valid_i && req_ready_o;
    assign pop          = resp_valid_o && resp_ready_i;

    always_comb begin
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_next  = new_entry;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_next = new_entry;
                end else if (push) begin
                    tail_next  = new_entry;
                    state_next = FULL;
                end else if (pop) begin
                    head_next  = '0;
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_next  = tail;
                    tail_next  = '0;
                    state_next = ONE;
                end
            end
            default: begin
                head_next  = '0;
                tail_next  = '0;
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            rd_count <= 8'd0;
        end else begin
            state <= state_next;
            head  <= head_next;
            tail  <= tail_next;
            if (pop) begin
                rd_count <= rd_count + 8'd1;
            end
        end
    end

    // Err bit is only ever set when READ_ERR_EN is defined, so this is 0 otherwise.
    assign resp_data_o = resp_valid_o ? head[REGISTER_WIDTH-1:0] : '0;
    assign resp_err_o  = resp_valid_o & head[REGISTER_WIDTH];
    assign rd_count_o  = rd_count;
    assign state_o     = state;

endmodule
